// File: rtl/cale_de_date_if.sv
// Handshake bundle between the LDH control path (master) and the
// leading-zero scan datapath (slave).
interface cale_de_date_if #(
    parameter int width = 8,
    parameter int cnt_w = 4
) ();
    logic             reset_cd;
    logic             load;
    logic [width-1:0] data_in;
    logic             busy;
    logic             done;
    logic [cnt_w-1:0] result;
    logic             zero_flag;

    modport master (
        output reset_cd,
        output load,
        output data_in,
        input  busy,
        input  done,
        input  result,
        input  zero_flag
    );

    modport slave (
        input  reset_cd,
        input  load,
        input  data_in,
        output busy,
        output done,
        output result,
        output zero_flag
    );
endinterface

// File: rtl/cale_de_date.sv
// Serial leading-zero counter: captures an operand on load, scans it MSB-first
// one bit per clock, then pulses done and holds the count until the next load or clear.
module cale_de_date #(
    parameter int width = 8,
    parameter int cnt_w = 4
) (
    input  logic           clk,
    input  logic           reset,
    cale_de_date_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_n;
    logic [width-1:0] shreg, shreg_n;
    logic [cnt_w-1:0] cnt, cnt_n;
    logic [cnt_w-1:0] result, result_n;
    logic             zero_flag, zero_flag_n;
    logic             busy, done;

    localparam logic [cnt_w-1:0] last_cnt  = cnt_w'(width - 1);
    localparam logic [cnt_w-1:0] all_zeros = cnt_w'(width);

    always_comb begin
        state_n     = state;
        shreg_n     = shreg;
        cnt_n       = cnt;
        result_n    = result;
        zero_flag_n = zero_flag;
        unique case (state)
            IDLE, DONE: begin
                state_n = IDLE;
                if (bus.load) begin
                    state_n     = SHIFT;
                    shreg_n     = bus.data_in;
                    cnt_n       = '0;
                    zero_flag_n = 1'b0;
                end
            end
            SHIFT: begin
                // The MSB test takes precedence so an operand whose only set
                // bit is the LSB reports width-1, not width.
                if (shreg[width-1]) begin
                    result_n = cnt;
                    state_n  = DONE;
                end else if (cnt == last_cnt) begin
                    result_n    = all_zeros;
                    zero_flag_n = 1'b1;
                    state_n     = DONE;
                end else begin
                    shreg_n = {shreg[width-2:0], 1'b0};
                    cnt_n   = cnt + cnt_w'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // busy/done are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!reset || bus.reset_cd) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            result    <= '0;
            zero_flag <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            shreg     <= shreg_n;
            cnt       <= cnt_n;
            result    <= result_n;
            zero_flag <= zero_flag_n;
            busy      <= (state_n == SHIFT);
            done      <= (state_n == DONE);
        end
    end

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.result    = result;
    assign bus.zero_flag = zero_flag;

endmodule

// File: doc/cale_de_date.md
Name: cale_de_date

Overview:
- Datapath stage directly downstream of the LDH control path. It consumes that stage's load and reset_cd strobes and returns busy to it.
- On load it captures a width-bit operand and scans it serially from the MSB, one bit per clock, to count leading zeros.
- It then presents the count and a one-cycle done pulse, and holds the result until the next load or clear.

Parameters:
- width, 8, operand width in bits (min 2).
- cnt_w, 4, width of result; must hold the value width (cnt_w >= clog2(width+1)).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- reset_cd  input  1  synchronous clear from control path, active-high.
- load  input  1  operand-capture strobe from control path, active-high.
- data_in  input  width  operand, sampled when load is accepted.
- busy  output  1  high while the scan is in progress; fed back to control path.
- done  output  1  one-cycle pulse when result becomes valid.
- result  output  cnt_w  leading-zero count, 0..width.
- zero_flag  output  1  high when the captured operand was all zeros.

Behaviour:
- Reset (reset==0 at clk edge):
  - Next state IDLE; shift register and counter cleared.
  - busy=0, done=0, result=0, zero_flag=0.
- Priority per edge: reset > reset_cd > load > normal state progression.
- reset_cd==1 (with reset==1): same effect as reset on the next edge.
  - Aborts any scan in progress; no done pulse is produced for it.
- States: IDLE, SHIFT, DONE. All outputs are registered.
- load acceptance:
  - load is accepted only when busy==0, i.e. in IDLE or DONE.
  - On an accepted load: shreg<=data_in, cnt<=0, zero_flag<=0, next state SHIFT.
  - result keeps its old value until overwritten at completion.
- Ignored loads: load while busy==1 is ignored; shreg, cnt and state are unaffected.
- SHIFT, evaluated once per cycle with busy=1:
  - If shreg[width-1]==1: result<=cnt, next state DONE.
  - Else if cnt==width-1: result<=width, zero_flag<=1, next state DONE.
  - Else: shreg<=shreg<<1 (LSB filled with 0), cnt<=cnt+1, stay in SHIFT.
- DONE: busy=0, done=1 for exactly one cycle.
  - Without load, next state is IDLE.
  - With load in the same cycle, next state is SHIFT; done still pulses in this cycle.
- IDLE: busy=0, done=0; result and zero_flag are held.
- Latency, with load sampled at edge k:
  - busy rises after edge k.
  - Leading-zero count n < width: SHIFT lasts n+1 cycles, done is high in cycle k+n+2, busy falls in that same cycle.
  - All-zero operand: SHIFT lasts width cycles, done is high in cycle k+width+1.
- Counter width: cnt never exceeds width-1 and result never exceeds width; no wrap-around is possible for legal cnt_w.
- data_in is don't-care except in the cycle a load is accepted.

Test Plan (width=8, cnt_w=4):
1. reset=0 for 2 cycles, then release -> busy=0, done=0, result=0, zero_flag=0.
2. load with data_in=8'h80 -> busy high 1 cycle; done in cycle k+2; result=0, zero_flag=0.
3. load with data_in=8'h01 -> busy high 8 cycles; done in cycle k+9; result=7, zero_flag=0. Repeat with 8'h00 -> done in cycle k+9, result=8, zero_flag=1.
4. load 8'h10, then pulse load with data_in=8'hFF at k+2 (busy=1) -> second load ignored; result=3, done in cycle k+5. Then assert load during the done cycle with 8'h40 -> accepted; result=1 two cycles later.
5. load 8'h00, assert reset_cd at k+3 -> busy=0 and result=0 after the next edge; done never pulses; a later load 8'h20 completes normally with result=2.
6. load 8'h00, drive reset=0 at k+4 with load=1 simultaneously -> reset wins; IDLE with all outputs 0; no done pulse.
